div_iter_pipe: RTL and testbench
================================

Name: div_iter_pipe

Overview:
- Parametrised iterative integer divider for the execute stage; successor to the fixed 32-bit stall-driven divider.
- Computes quotient or remainder, signed or unsigned, for WIDTH-bit operands.
- Uses a valid/ready handshake on both sides instead of a stall output, plus flush support and defined divide-by-zero and overflow results.
- Carries an opaque destination tag through to the result.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4, power of two).
- TAG_W, 5, width of the destination tag carried with each operation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  abort any in-flight operation; no result is produced for it.
- in_valid  in  1  request valid.
- in_ready  out  1  divider can accept a request this cycle.
- in_op  in  1  1 = quotient, 0 = remainder.
- in_sign  in  1  1 = signed (two's complement), 0 = unsigned.
- in_src0  in  WIDTH  dividend.
- in_src1  in  WIDTH  divisor.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  quotient or remainder.
- out_tag  out  TAG_W  tag of the result.
- out_dbz  out  1  divisor was zero.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. in_ready=1; out_valid=0; out_result=0; out_tag=0; out_dbz=0; busy=0. Reset mid-operation discards the operation.
- Handshake: a request is accepted when in_valid&&in_ready. A result is retired when out_valid&&out_ready. While out_valid=1 the signals out_result, out_tag and out_dbz are held stable. in_ready=1 only in IDLE.
- Only one operation is in flight at a time.
- States:
  - IDLE: on accept, latch op, sign, tag, |src0| into rem and |src1| into dvs. Latch sign flags: s0 = sign&src0[W-1], s1 = sign&src1[W-1]. Go to PRE.
  - PRE: compute leading-zero counts lz0 and lz1.
    - dvs==0 → DONE, with quotient = all ones, remainder = src0 (original value), dbz=1.
    - |src0| < |src1| → DONE, with quotient = 0, remainder = src0.
    - Otherwise k = lz1 - lz0. Set dvs <<= k, q=0, cnt=k. Go to ITER.
  - ITER: each cycle, if rem ≥ dvs then rem -= dvs and q = {q,1}; else q = {q,0}. Then dvs >>= 1. When cnt==0 go to FIX, else cnt--. Total iterations = k+1.
  - FIX: apply signs. Quotient is negated if s0^s1. Remainder is negated if s0 (remainder takes the sign of the dividend). Go to DONE.
  - DONE: out_valid=1. On out_ready → IDLE. A new request may be accepted on the cycle after retirement, not on the same cycle.
- Latency from accept to out_valid:
  - Early path (dbz or |src0|<|src1|): 2 cycles.
  - General case: k+4 cycles.
  - Worst case: WIDTH+3 cycles.
- Signed overflow (src0 = MIN, src1 = -1): quotient = MIN, remainder = 0. This falls out of the W-bit wrap and needs no special case.
- Arithmetic: magnitudes are held in W bits. The shifted divisor dvs is held in W bits. Shifting is safe because k ≤ lz1.
- flush: forces IDLE next cycle from any state, including DONE with out_valid=1 (the result is dropped). flush has priority over an accept in the same cycle (the request is not accepted). rst has priority over flush.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: PRE uses leading-zero normalisation and the |src0|<|src1| shortcut, so latency is variable as given above.
- Undefined: PRE always sets k = WIDTH-1 with no dvs pre-shift. The compare runs against a 2W-bit partial remainder, so latency is a fixed WIDTH+3 cycles for every non-dbz operand. dbz still takes the 2-cycle path. Results are identical in both builds.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE, PRE, ITER, FIX, DONE);
  - op encoding constants DIV_OP_QUO=1, DIV_OP_REM=0;
  - a function giving the DBZ quotient constant for WIDTH.
- Sub-module clz_w: parametrised leading-zero counter (WIDTH in, $clog2(WIDTH)+1 out, returns WIDTH for zero input). It is instantiated twice in PRE.

Test Plan:
- Unsigned quotient: src0=100, src1=7, op=1, sign=0 → result 14. Under DIV_EARLY_OUT_EN: k=4, out_valid 8 cycles after accept.
- Signed remainder: src0=-7 (0xFFFFFFF9), src1=2, op=0, sign=1 → result -1 (0xFFFFFFFF). Same operands with op=1 → -3 (0xFFFFFFFD).
- Divide by zero: src0=0x1234, src1=0, op=1 → 0xFFFFFFFF with out_dbz=1. With op=0 → 0x1234. out_valid 2 cycles after accept.
- Overflow: src0=0x80000000, src1=0xFFFFFFFF, signed, op=1 → 0x80000000. With op=0 → 0.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles: result and tag stay stable, in_ready=0.
  - Assert flush during ITER: no out_valid, in_ready=1 next cycle.
  - flush and in_valid in the same IDLE cycle: request not accepted.
- Parametrisation: WIDTH=8, TAG_W=3, random signed/unsigned operands compared against a reference model. Worst-case latency is 11 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider (div_iter_pipe).
package div_pkg;

  // Controller states of the divider.
  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ITER,
    FIX,
    DONE
  } div_state_e;

  // Operation select encoding carried on in_op.
  localparam logic DIV_OP_QUO = 1'b1;
  localparam logic DIV_OP_REM = 1'b0;

  // Quotient returned for a zero divisor: all ones in the low 'width' bits.
  // Callers truncate to their own width. Supports widths up to 128.
  function automatic logic [127:0] div_dbz_quo(input int width);
    return (128'd1 << width) - 128'd1;
  endfunction

endpackage

// File: rtl/div_iter_pipe_if.sv
// Request/result handshake bundle of the iterative divider.
// master = the issuing pipeline stage, slave = the divider.
interface div_iter_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic             in_sign;
  logic [WIDTH-1:0] in_src0;
  logic [WIDTH-1:0] in_src1;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_sign, in_src0, in_src1, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_dbz, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_sign, in_src0, in_src1, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_dbz, busy
  );
endinterface

// File: rtl/div_iter_pipe_clz.sv
// clz_w: leading-zero counter. Returns WIDTH when the input is zero.
module clz_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       din,
  output logic [$clog2(WIDTH):0] count
);

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    count = ($clog2(WIDTH) + 1)'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) count = ($clog2(WIDTH) + 1)'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_iter_pipe.sv
// div_iter_pipe: iterative restoring divider, quotient or remainder,
// signed or unsigned, with valid/ready handshake, flush and a tag.
// Build option DIV_EARLY_OUT_EN: leading-zero normalisation plus the
// |src0|<|src1| shortcut give variable latency; without it every non-zero
// divisor runs WIDTH iterations against a 2*WIDTH-bit shifted divisor.
module div_iter_pipe
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           rst,
  div_iter_pipe_if.slave dif
);

  localparam int CW = $clog2(WIDTH) + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int DVS_W = WIDTH;
`else
  localparam int DVS_W = 2 * WIDTH;
`endif
  localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(div_dbz_quo(WIDTH));

  div_state_e       state_q, state_d;
  logic             op_q, s0_q, s1_q, dbz_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] rem_q, q_q, result_q;
  logic [DVS_W-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, src0_neg, src1_neg, dvs_zero, rem_ge;
  logic [WIDTH-1:0] abs0, abs1, rem_diff, signed_quo, signed_rem;
  logic [DVS_W-1:0] rem_ext;
  logic [CW-1:0]    lz0, lz1;

  assign dif.in_ready   = (state_q == IDLE);
  assign dif.out_valid  = (state_q == DONE);
  assign dif.busy       = (state_q != IDLE);
  assign dif.out_result = result_q;
  assign dif.out_tag    = tag_q;
  assign dif.out_dbz    = dbz_q;

  // A flush in the same cycle wins over a new request.
  assign accept   = dif.in_valid && dif.in_ready && !dif.flush;
  assign src0_neg = dif.in_sign && dif.in_src0[WIDTH-1];
  assign src1_neg = dif.in_sign && dif.in_src1[WIDTH-1];
  assign abs0     = src0_neg ? -dif.in_src0 : dif.in_src0;
  assign abs1     = src1_neg ? -dif.in_src1 : dif.in_src1;

  assign rem_ext    = DVS_W'(rem_q);
  assign rem_ge     = (rem_ext >= dvs_q);
  assign rem_diff   = rem_q - dvs_q[WIDTH-1:0];
  assign signed_quo = (s0_q ^ s1_q) ? -q_q : q_q;
  assign signed_rem = s0_q ? -rem_q : rem_q;
  assign dvs_zero   = (lz1 == CW'(WIDTH));

  clz_w #(.WIDTH(WIDTH)) u_clz0 (.din(rem_q), .count(lz0));
  clz_w #(.WIDTH(WIDTH)) u_clz1 (.din(dvs_q[WIDTH-1:0]), .count(lz1));

`ifdef DIV_EARLY_OUT_EN
  logic          small;
  logic [CW-1:0] k;
  assign small = (rem_q < dvs_q[WIDTH-1:0]);
  assign k     = lz1 - lz0;
`else
  logic unused_lz0;
  assign unused_lz0 = ^lz0;
`endif

  // State register; reset discards any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush returns to IDLE from anywhere, dropping results.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = PRE;
      PRE: begin
        if (dvs_zero) state_d = DONE;
`ifdef DIV_EARLY_OUT_EN
        else if (small) state_d = DONE;
`endif
        else state_d = ITER;
      end
      ITER: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (dif.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.flush) state_d = IDLE;
  end

  // Datapath: latch operands, normalise, shift-subtract, then apply signs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 1'b0;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      dbz_q    <= 1'b0;
      tag_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= dif.in_op;
            s0_q  <= src0_neg;
            s1_q  <= src1_neg;
            tag_q <= dif.in_tag;
            rem_q <= abs0;
            dvs_q <= DVS_W'(abs1);
            dbz_q <= 1'b0;
          end
        end
        PRE: begin
          if (dvs_zero) begin
            result_q <= (op_q == DIV_OP_QUO) ? DBZ_Q : signed_rem;
            dbz_q    <= 1'b1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (small) begin
            result_q <= (op_q == DIV_OP_QUO) ? '0 : signed_rem;
          end else begin
            dvs_q <= dvs_q << k;
            cnt_q <= k;
            q_q   <= '0;
          end
`else
          else begin
            dvs_q <= dvs_q << (WIDTH - 1);
            cnt_q <= CW'(WIDTH - 1);
            q_q   <= '0;
          end
`endif
        end
        ITER: begin
          if (rem_ge) rem_q <= rem_diff;
          q_q   <= {q_q[WIDTH-2:0], rem_ge};
          dvs_q <= dvs_q >> 1;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          result_q <= (op_q == DIV_OP_QUO) ? signed_quo : signed_rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_pipe.sv
// Directed self-checking bench for div_iter_pipe: a 32-bit and an 8-bit
// instance share clock and reset. Latency expectations follow the
// DIV_EARLY_OUT_EN build option.
module tb_div_iter_pipe;
  import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_100_7 = 8;
  localparam int LAT_SMALL = 2;
  localparam int LAT_BIG   = 31;
  localparam int LAT_N8    = 8;
`else
  localparam int LAT_100_7 = 35;
  localparam int LAT_SMALL = 35;
  localparam int LAT_BIG   = 35;
  localparam int LAT_N8    = 11;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_pipe_if #(.WIDTH(32), .TAG_W(5)) dif ();
  div_iter_pipe_if #(.WIDTH(8), .TAG_W(3))  dif8 ();

  div_iter_pipe #(.WIDTH(32), .TAG_W(5)) dut  (.clk(clk), .rst(rst), .dif(dif));
  div_iter_pipe #(.WIDTH(8), .TAG_W(3))  dut8 (.clk(clk), .rst(rst), .dif(dif8));

  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] obsResult, obsValid, obsTag, obsDbz, obsBusy, obsInReady;
  int          obsLat;
  int          sawValid;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its result to appear.
  task automatic applyStimulus(input bit narrow, input logic op, input logic sign,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    logic v;
    if (narrow) begin
      dif8.in_valid = 1'b1; dif8.in_op = op; dif8.in_sign = sign;
      dif8.in_src0 = a[7:0]; dif8.in_src1 = b[7:0]; dif8.in_tag = tag[2:0];
    end else begin
      dif.in_valid = 1'b1; dif.in_op = op; dif.in_sign = sign;
      dif.in_src0 = a; dif.in_src1 = b; dif.in_tag = tag;
    end
    @(posedge clk); #1;
    dif.in_valid  = 1'b0;
    dif8.in_valid = 1'b0;
    obsLat = 1;
    v = narrow ? dif8.out_valid : dif.out_valid;
    while (!v && obsLat < 60) begin
      @(posedge clk); #1;
      obsLat++;
      v = narrow ? dif8.out_valid : dif.out_valid;
    end
    obsValid   = 32'(v);
    obsResult  = narrow ? {24'b0, dif8.out_result} : dif.out_result;
    obsTag     = narrow ? 32'(dif8.out_tag) : 32'(dif.out_tag);
    obsDbz     = narrow ? 32'(dif8.out_dbz) : 32'(dif.out_dbz);
    obsBusy    = narrow ? 32'(dif8.busy) : 32'(dif.busy);
    obsInReady = narrow ? 32'(dif8.in_ready) : 32'(dif.in_ready);
  endtask

  task automatic retire(input bit narrow);
    if (narrow) dif8.out_ready = 1'b1;
    else        dif.out_ready  = 1'b1;
    @(posedge clk); #1;
    dif.out_ready  = 1'b0;
    dif8.out_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input bit narrow, input logic op, input logic sign,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] expRes, input logic expDbz, input int expLat);
    applyStimulus(narrow, op, sign, a, b, tag);
    checkOutput({name, ".valid"}, obsValid, 32'd1);
    checkOutput({name, ".result"}, obsResult, expRes);
    checkOutput({name, ".tag"}, obsTag, 32'(tag));
    checkOutput({name, ".dbz"}, obsDbz, 32'(expDbz));
    checkOutput({name, ".busy"}, obsBusy, 32'd1);
    checkOutput({name, ".in_ready"}, obsInReady, 32'd0);
    if (expLat > 0) checkOutput({name, ".latency"}, 32'(obsLat), 32'(expLat));
    retire(narrow);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    dif.flush = 1'b0;  dif.in_valid = 1'b0;  dif.out_ready = 1'b0;
    dif.in_op = 1'b0;  dif.in_sign = 1'b0;   dif.in_src0 = '0; dif.in_src1 = '0; dif.in_tag = '0;
    dif8.flush = 1'b0; dif8.in_valid = 1'b0; dif8.out_ready = 1'b0;
    dif8.in_op = 1'b0; dif8.in_sign = 1'b0;  dif8.in_src0 = '0; dif8.in_src1 = '0; dif8.in_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset.in_ready", 32'(dif.in_ready), 32'd1);
    checkOutput("reset.out_valid", 32'(dif.out_valid), 32'd0);
    checkOutput("reset.out_result", dif.out_result, 32'd0);
    checkOutput("reset.out_tag", 32'(dif.out_tag), 32'd0);
    checkOutput("reset.out_dbz", 32'(dif.out_dbz), 32'd0);
    checkOutput("reset.busy", 32'(dif.busy), 32'd0);

    runOp("uquo_100_7",   0, DIV_OP_QUO, 1'b0, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, LAT_100_7);
    runOp("urem_100_7",   0, DIV_OP_REM, 1'b0, 32'd100, 32'd7, 5'd17, 32'd2, 1'b0, -1);
    runOp("srem_m7_2",    0, DIV_OP_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 1'b0, -1);
    runOp("squo_m7_2",    0, DIV_OP_QUO, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0, -1);
    runOp("squo_7_m2",    0, DIV_OP_QUO, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFD, 1'b0, -1);
    runOp("srem_7_m2",    0, DIV_OP_REM, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 1'b0, -1);
    runOp("uquo_fff9_2",  0, DIV_OP_QUO, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h7FFF_FFFC, 1'b0, -1);
    runOp("dbz_quo",      0, DIV_OP_QUO, 1'b0, 32'h1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b1, 2);
    runOp("dbz_rem",      0, DIV_OP_REM, 1'b0, 32'h1234, 32'd0, 5'd11, 32'h1234, 1'b1, 2);
    runOp("sdbz_rem_m7",  0, DIV_OP_REM, 1'b1, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFF9, 1'b1, 2);
    runOp("ovf_quo",      0, DIV_OP_QUO, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1'b0, -1);
    runOp("ovf_rem",      0, DIV_OP_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1'b0, -1);
    runOp("small_urem",   0, DIV_OP_REM, 1'b0, 32'd5, 32'd9, 5'd15, 32'd5, 1'b0, LAT_SMALL);
    runOp("small_squo",   0, DIV_OP_QUO, 1'b1, 32'hFFFF_FFFB, 32'd9, 5'd16, 32'd0, 1'b0, -1);
    runOp("small_srem",   0, DIV_OP_REM, 1'b1, 32'hFFFF_FFFB, 32'd9, 5'd18, 32'hFFFF_FFFB, 1'b0, -1);
    runOp("uquo_big",     0, DIV_OP_QUO, 1'b0, 32'hFFFF_FFFF, 32'h10, 5'd19, 32'h0FFF_FFFF, 1'b0, LAT_BIG);
    runOp("urem_big",     0, DIV_OP_REM, 1'b0, 32'hFFFF_FFFF, 32'h10, 5'd20, 32'hF, 1'b0, -1);
    runOp("worst32",      0, DIV_OP_QUO, 1'b0, 32'h8000_0000, 32'd1, 5'd21, 32'h8000_0000, 1'b0, 35);

    // Backpressure: result held while out_ready stays low; a second request is refused.
    applyStimulus(0, DIV_OP_QUO, 1'b0, 32'd100, 32'd7, 5'd9);
    checkOutput("bp.valid0", obsValid, 32'd1);
    dif.in_valid = 1'b1; dif.in_src0 = 32'd50; dif.in_src1 = 32'd5; dif.in_tag = 5'd2;
    repeat (5) @(posedge clk);
    #1 dif.in_valid = 1'b0;
    checkOutput("bp.valid", 32'(dif.out_valid), 32'd1);
    checkOutput("bp.result", dif.out_result, 32'd14);
    checkOutput("bp.tag", 32'(dif.out_tag), 32'd9);
    checkOutput("bp.in_ready", 32'(dif.in_ready), 32'd0);
    retire(0);
    checkOutput("bp.idle_in_ready", 32'(dif.in_ready), 32'd1);
    checkOutput("bp.idle_valid", 32'(dif.out_valid), 32'd0);

    // Flush during ITER: the operation vanishes.
    dif.in_valid = 1'b1; dif.in_op = DIV_OP_QUO; dif.in_sign = 1'b0;
    dif.in_src0 = 32'd100; dif.in_src1 = 32'd7; dif.in_tag = 5'd4;
    @(posedge clk); #1 dif.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("flush_iter.busy", 32'(dif.busy), 32'd1);
    dif.flush = 1'b1;
    @(posedge clk); #1 dif.flush = 1'b0;
    checkOutput("flush_iter.in_ready", 32'(dif.in_ready), 32'd1);
    checkOutput("flush_iter.valid", 32'(dif.out_valid), 32'd0);
    sawValid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.out_valid) sawValid++;
    end
    checkOutput("flush_iter.no_result", 32'(sawValid), 32'd0);

    // Flush while a result is waiting in DONE drops it.
    applyStimulus(0, DIV_OP_QUO, 1'b0, 32'h1234, 32'd0, 5'd22);
    checkOutput("flush_done.valid0", obsValid, 32'd1);
    dif.flush = 1'b1;
    @(posedge clk); #1 dif.flush = 1'b0;
    checkOutput("flush_done.valid", 32'(dif.out_valid), 32'd0);
    checkOutput("flush_done.in_ready", 32'(dif.in_ready), 32'd1);

    // Flush and in_valid together in IDLE: request is not taken.
    dif.in_valid = 1'b1; dif.flush = 1'b1; dif.in_src0 = 32'd9; dif.in_src1 = 32'd3;
    @(posedge clk); #1;
    dif.in_valid = 1'b0; dif.flush = 1'b0;
    checkOutput("flush_accept.busy", 32'(dif.busy), 32'd0);
    checkOutput("flush_accept.in_ready", 32'(dif.in_ready), 32'd1);

    // Reset mid-operation clears everything.
    dif.in_valid = 1'b1; dif.in_src0 = 32'd100; dif.in_src1 = 32'd7; dif.in_tag = 5'd7;
    @(posedge clk); #1 dif.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checkOutput("rst_mid.in_ready", 32'(dif.in_ready), 32'd1);
    checkOutput("rst_mid.valid", 32'(dif.out_valid), 32'd0);
    checkOutput("rst_mid.tag", 32'(dif.out_tag), 32'd0);
    checkOutput("rst_mid.result", dif.out_result, 32'd0);

    // 8-bit instance.
    runOp("n8.worst_u",   1, DIV_OP_QUO, 1'b0, 32'h80, 32'h01, 5'd5, 32'h80, 1'b0, 11);
    runOp("n8.ovf_quo",   1, DIV_OP_QUO, 1'b1, 32'h80, 32'hFF, 5'd6, 32'h80, 1'b0, 11);
    runOp("n8.squo_m100", 1, DIV_OP_QUO, 1'b1, 32'h9C, 32'h07, 5'd1, 32'hF2, 1'b0, LAT_N8);
    runOp("n8.srem_m100", 1, DIV_OP_REM, 1'b1, 32'h9C, 32'h07, 5'd2, 32'hFE, 1'b0, -1);
    runOp("n8.uquo_200",  1, DIV_OP_QUO, 1'b0, 32'd200, 32'd13, 5'd3, 32'h0F, 1'b0, -1);
    runOp("n8.urem_200",  1, DIV_OP_REM, 1'b0, 32'd200, 32'd13, 5'd4, 32'h05, 1'b0, -1);
    runOp("n8.squo_100",  1, DIV_OP_QUO, 1'b1, 32'd100, 32'hF7, 5'd7, 32'hF5, 1'b0, -1);
    runOp("n8.srem_100",  1, DIV_OP_REM, 1'b1, 32'd100, 32'hF7, 5'd0, 32'h01, 1'b0, -1);
    runOp("n8.dbz_quo",   1, DIV_OP_QUO, 1'b0, 32'h5A, 32'h00, 5'd5, 32'hFF, 1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
